// File: rtl/or1k_rf_port_ctrl.sv
// GPR RAM write-port arbiter (writeback > clear > SPR write) plus SPR-bus GPR read sequencer with write bypass.
// SPR write acks in the strobe cycle when the port is free; SPR read acks two cycles after the strobe is taken.
module or1k_rf_port_ctrl #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int RF_ADDR_WIDTH        = 5,
  parameter int OPTION_RF_WORDS      = 32,
  parameter int CLEAR_ON_RESET       = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wb_rf_wb_i,
  input  logic [RF_ADDR_WIDTH-1:0]        wb_rfd_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
  input  logic [15:0]                     spr_bus_addr_i,
  input  logic                            spr_bus_stb_i,
  input  logic                            spr_bus_we_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i,
  output logic                            spr_gpr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] spr_gpr_dat_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_dout_i,
  output logic                            rf_re_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_raddr_o,
  output logic                            rf_we_o,
  output logic [RF_ADDR_WIDTH-1:0]        rf_waddr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rf_wdat_o,
  output logic                            init_busy_o
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_ACK, S_HOLD} state_t;

  localparam logic [RF_ADDR_WIDTH-1:0] LAST_WORD = RF_ADDR_WIDTH'(OPTION_RF_WORDS - 1);

  state_t                          state_q, state_d;
  logic [RF_ADDR_WIDTH-1:0]        cnt_q;
  logic [RF_ADDR_WIDTH-1:0]        rd_adr_q;
  logic                            rd_oor_q;
  logic                            byp_vld_q;
  logic [OPTION_OPERAND_WIDTH-1:0] byp_dat_q;
  logic [OPTION_OPERAND_WIDTH-1:0] dat_q;

  logic                            gpr_hit;
  logic                            in_range;
  logic [RF_ADDR_WIDTH-1:0]        spr_adr;
  logic                            we_c, re_c, ack_c;
  logic [RF_ADDR_WIDTH-1:0]        waddr_c, raddr_c;
  logic [OPTION_OPERAND_WIDTH-1:0] wdat_c;
  logic                            cnt_inc, rd_start, rd_cap, byp_clr;

  assign gpr_hit  = spr_bus_stb_i && (spr_bus_addr_i[15:9] == 7'h2);
  assign in_range = ((spr_bus_addr_i[8:0] >> RF_ADDR_WIDTH) == 9'd0);
  assign spr_adr  = spr_bus_addr_i[RF_ADDR_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    we_c     = 1'b0;
    waddr_c  = '0;
    wdat_c   = '0;
    re_c     = 1'b0;
    raddr_c  = '0;
    ack_c    = 1'b0;
    cnt_inc  = 1'b0;
    rd_start = 1'b0;
    rd_cap   = 1'b0;
    byp_clr  = 1'b0;

    // Writeback owns the write port whenever it asks, in every state.
    if (wb_rf_wb_i) begin
      we_c    = 1'b1;
      waddr_c = wb_rfd_adr_i;
      wdat_c  = result_i;
    end

    case (state_q)
      S_INIT: begin
        if (!wb_rf_wb_i) begin
          we_c    = 1'b1;
          waddr_c = cnt_q;
          wdat_c  = '0;
          cnt_inc = 1'b1;
          if (cnt_q == LAST_WORD) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (gpr_hit) begin
          if (spr_bus_we_i) begin
            if (!in_range) begin
              ack_c   = 1'b1;
              state_d = S_HOLD;
            end else if (!wb_rf_wb_i) begin
              we_c    = 1'b1;
              waddr_c = spr_adr;
              wdat_c  = spr_bus_dat_i;
              ack_c   = 1'b1;
              state_d = S_HOLD;
            end
          end else begin
            re_c     = in_range;
            raddr_c  = spr_adr;
            rd_start = 1'b1;
            state_d  = S_RD;
          end
        end
      end
      S_RD: begin
        rd_cap  = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack_c   = 1'b1;
        byp_clr = 1'b1;
        state_d = S_IDLE;
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rf_we_o       = we_c && !rst;
  assign rf_waddr_o    = waddr_c;
  assign rf_wdat_o     = wdat_c;
  assign rf_re_o       = re_c && !rst;
  assign rf_raddr_o    = raddr_c;
  assign spr_gpr_ack_o = ack_c && !rst;
  assign spr_gpr_dat_o = dat_q;
  assign init_busy_o   = (state_q == S_INIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? S_INIT : S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_inc) cnt_q <= (cnt_q == LAST_WORD) ? '0 : cnt_q + 1'b1;
    end
  end

  // RAM read is read-before-write, so a write landing in the read cycle or the next one must be forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_adr_q  <= '0;
      rd_oor_q  <= 1'b0;
      byp_vld_q <= 1'b0;
      byp_dat_q <= '0;
      dat_q     <= '0;
    end else begin
      if (rd_start) begin
        rd_adr_q  <= spr_adr;
        rd_oor_q  <= !in_range;
        byp_vld_q <= in_range && we_c && (waddr_c == spr_adr);
        if (we_c) byp_dat_q <= wdat_c;
      end else if (byp_clr) begin
        byp_vld_q <= 1'b0;
      end
      if (rd_cap) begin
        if (rd_oor_q)                         dat_q <= '0;
        else if (we_c && waddr_c == rd_adr_q) dat_q <= wdat_c;
        else if (byp_vld_q)                   dat_q <= byp_dat_q;
        else                                  dat_q <= rf_dout_i;
      end
    end
  end

endmodule
